// File: rtl/dog_anim_ctrl_pkg.sv
// dog_ctrl_pkg: shared types, frame indices and coordinate helper for the dog sequencer.
package dog_ctrl_pkg;
  localparam int CW = 11;
  localparam int SW = 4;
  typedef enum logic [3:0] {IDLE, WALK, SNIFF, ALERT, JUMP_UP, JUMP_DOWN, HIDDEN, RISE, HOLD, FALL} state_t;
  localparam logic [SW-1:0] DOG_WALK0 = 4'd0;
  localparam logic [SW-1:0] DOG_WALK1 = 4'd1;
  localparam logic [SW-1:0] DOG_WALK2 = 4'd2;
  localparam logic [SW-1:0] DOG_WALK3 = 4'd3;
  localparam logic [SW-1:0] DOG_SNIFF = 4'd4;
  localparam logic [SW-1:0] DOG_ALERT = 4'd5;
  localparam logic [SW-1:0] DOG_JUMP_UP = 4'd6;
  localparam logic [SW-1:0] DOG_JUMP_DOWN = 4'd7;
  localparam logic [SW-1:0] DOG_LAUGH = 4'd8;
  // Move cur toward tgt by at most d, landing exactly on tgt without overshoot.
  function automatic logic [CW-1:0] step_to(input logic [CW-1:0] cur, input logic [CW-1:0] tgt, input logic [CW-1:0] d);
    return cur < tgt ? (tgt - cur <= d ? tgt : cur + d) : (cur - tgt <= d ? tgt : cur - d);
  endfunction
endpackage

// File: rtl/dog_anim_ctrl_if.sv
// dog_anim_ctrl_if: game-side controls and dog draw/ROM outputs of the sequencer.
interface dog_anim_ctrl_if;
  import dog_ctrl_pkg::*;
  logic frame_tick;
  logic start_intro;
  logic duck_hit;
  logic duck_miss;
  logic [CW-1:0] bird_x;
  logic [SW-1:0] dog_select;
  logic [CW-1:0] dog_xpos;
  logic [CW-1:0] dog_ypos;
  logic dog_visible;
  logic show_bird;
  logic busy;
  logic intro_done;
  logic round_done;
  modport master(output frame_tick, start_intro, duck_hit, duck_miss, bird_x,
                 input dog_select, dog_xpos, dog_ypos, dog_visible, show_bird, busy, intro_done, round_done);
  modport slave(input frame_tick, start_intro, duck_hit, duck_miss, bird_x,
                output dog_select, dog_xpos, dog_ypos, dog_visible, show_bird, busy, intro_done, round_done);
endinterface

// File: rtl/dog_tick_timer.sv
// dog_tick_timer: frame-tick down counter; expired marks the tick that completes the loaded duration.
module dog_tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt <= W'(1);
endmodule

// File: rtl/dog_anim_ctrl.sv
// dog_anim_ctrl: dog sprite sequencer for the intro walk/sniff/jump and the round-end reaction.
module dog_anim_ctrl
  import dog_ctrl_pkg::*;
#(
  parameter int WALK_START_X = 0,
  parameter int WALK_END_X = 200,
  parameter int STEP_PX = 2,
  parameter int FRAMES_PER_STEP = 6,
  parameter int GROUND_Y = 560,
  parameter int JUMP_PEAK_Y = 460,
  parameter int HIDE_Y = 620,
  parameter int SHOW_Y = 540,
  parameter int JUMP_PX = 4,
  parameter int RISE_PX = 2,
  parameter int SNIFF_TICKS = 40,
  parameter int ALERT_TICKS = 20,
  parameter int HOLD_TICKS = 60
) (
  input logic clk,
  input logic rst,
  dog_anim_ctrl_if.slave bus
);
  localparam int TMAX = SNIFF_TICKS > ALERT_TICKS ? (SNIFF_TICKS > HOLD_TICKS ? SNIFF_TICKS : HOLD_TICKS)
                                                  : (ALERT_TICKS > HOLD_TICKS ? ALERT_TICKS : HOLD_TICKS);
  localparam int TW = $clog2(TMAX + 2);
  localparam int FW = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CW-1:0] X0 = CW'(WALK_START_X);
  localparam logic [CW-1:0] XE = CW'(WALK_END_X);
  localparam logic [CW-1:0] GY = CW'(GROUND_Y);
  localparam logic [CW-1:0] PK = CW'(JUMP_PEAK_Y);
  localparam logic [CW-1:0] HY = CW'(HIDE_Y);
  localparam logic [CW-1:0] SY = CW'(SHOW_Y);
  state_t st, st_n;
  logic [SW-1:0] sel, sel_n;
  logic [CW-1:0] x, x_n, y, y_n;
  logic [FW-1:0] wcnt, wcnt_n;
  logic vis, vis_n, bird, bird_n, busy_r, intro_r, intro_n, round_r, round_n;
  logic t_load, t_exp;
  logic [TW-1:0] t_val;
  wire tick = bus.frame_tick;
  wire wlast = wcnt == FW'(FRAMES_PER_STEP - 1);
  dog_tick_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .tick(tick), .load(t_load), .load_val(t_val), .expired(t_exp)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      sel <= DOG_WALK0;
      x <= X0;
      y <= GY;
      wcnt <= '0;
      vis <= 1'b0;
      bird <= 1'b0;
      busy_r <= 1'b0;
      intro_r <= 1'b0;
      round_r <= 1'b0;
    end else begin
      st <= st_n;
      sel <= sel_n;
      x <= x_n;
      y <= y_n;
      wcnt <= wcnt_n;
      vis <= vis_n;
      bird <= bird_n;
      busy_r <= st_n != IDLE && st_n != HIDDEN;
      intro_r <= intro_n;
      round_r <= round_n;
    end
  always_comb begin
    st_n = st;
    sel_n = sel;
    x_n = x;
    y_n = y;
    wcnt_n = wcnt;
    vis_n = vis;
    bird_n = bird;
    intro_n = 1'b0;
    round_n = 1'b0;
    t_load = 1'b0;
    t_val = '0;
    case (st)
      IDLE, HIDDEN:
        if (bus.start_intro) begin
          st_n = WALK;
          x_n = X0;
          y_n = GY;
          sel_n = DOG_WALK0;
          wcnt_n = '0;
          vis_n = 1'b1;
          bird_n = 1'b0;
        end else if (st == HIDDEN && (bus.duck_hit || bus.duck_miss)) begin
          st_n = RISE;
          x_n = bus.duck_hit ? bus.bird_x : XE;
          y_n = HY;
          sel_n = bus.duck_hit ? sel : DOG_LAUGH;
          vis_n = 1'b1;
          bird_n = bus.duck_hit;
        end
      WALK:
        if (tick) begin
          x_n = step_to(x, XE, CW'(STEP_PX));
          wcnt_n = wlast ? '0 : wcnt + 1'b1;
          sel_n = wlast ? {2'b00, sel[1:0] + 2'd1} : sel;
          if (x_n == XE) begin
            st_n = SNIFF;
            sel_n = DOG_SNIFF;
            t_load = 1'b1;
            t_val = TW'(SNIFF_TICKS);
          end
        end
      SNIFF:
        if (tick && t_exp) begin
          st_n = ALERT;
          sel_n = DOG_ALERT;
          t_load = 1'b1;
          t_val = TW'(ALERT_TICKS);
        end
      ALERT:
        if (tick && t_exp) begin
          st_n = JUMP_UP;
          sel_n = DOG_JUMP_UP;
        end
      JUMP_UP:
        if (tick) begin
          y_n = step_to(y, PK, CW'(JUMP_PX));
          x_n = x + 1'b1;
          if (y_n == PK) begin
            st_n = JUMP_DOWN;
            sel_n = DOG_JUMP_DOWN;
          end
        end
      JUMP_DOWN:
        if (tick) begin
          y_n = step_to(y, HY, CW'(JUMP_PX));
          if (y_n == HY) begin
            st_n = HIDDEN;
            vis_n = 1'b0;
            intro_n = 1'b1;
          end
        end
      RISE:
        if (tick) begin
          y_n = step_to(y, SY, CW'(RISE_PX));
          if (y_n == SY) begin
            st_n = HOLD;
            t_load = 1'b1;
            t_val = TW'(HOLD_TICKS);
          end
        end
      HOLD: st_n = tick && t_exp ? FALL : HOLD;
      FALL:
        if (tick) begin
          y_n = step_to(y, HY, CW'(RISE_PX));
          if (y_n == HY) begin
            st_n = HIDDEN;
            vis_n = 1'b0;
            bird_n = 1'b0;
            round_n = 1'b1;
          end
        end
      default: st_n = IDLE;
    endcase
  end
  assign bus.dog_select = sel;
  assign bus.dog_xpos = x;
  assign bus.dog_ypos = y;
  assign bus.dog_visible = vis;
  assign bus.show_bird = bird;
  assign bus.busy = busy_r;
  assign bus.intro_done = intro_r;
  assign bus.round_done = round_r;
endmodule

// File: tb/tb_dog_anim_ctrl.sv
// tb_dog_anim_ctrl: randomized-timing bench comparing the dog sequencer with a closed-form timeline model.
module tb_dog_anim_ctrl;
  localparam int WSTART = 0, WEND = 200, STEP = 2, FPS = 6, GY = 560, PK = 460, HY = 620, SY = 540;
  localparam int JP = 4, RP = 2, SNIFF_T = 40, ALERT_T = 20, HOLD_T = 60;
  localparam int WT = (WEND - WSTART) / STEP;
  localparam int JU = (GY - PK) / JP;
  localparam int JD = (HY - PK) / JP;
  localparam int INTRO_T = WT + SNIFF_T + ALERT_T + JU + JD;
  localparam int RT = (HY - SY) / RP;
  localparam int ROUND_T = 2 * RT + HOLD_T;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] last_sel = 4'd0;
  always #5 clk = ~clk;
  dog_anim_ctrl_if bus();
  dog_anim_ctrl dut(.clk(clk), .rst(rst), .bus(bus));
  wire [30:0] obs = {bus.dog_select, bus.dog_xpos, bus.dog_ypos, bus.dog_visible, bus.show_bird,
                     bus.busy, bus.intro_done, bus.round_done};
  function automatic logic [30:0] pack(int s, int x, int y, bit v, bit b, bit bz, bit id, bit rd);
    return {4'(s), 11'(x), 11'(y), v, b, bz, id, rd};
  endfunction
  // Outputs after k frame ticks of the intro; fresh = the k-th tick happened on the last edge.
  function automatic logic [30:0] intro_exp(int k, bit fresh);
    int j;
    if (k < WT) return pack((k / FPS) % 4, WSTART + STEP * k, GY, 1, 0, 1, 0, 0);
    if (k < WT + SNIFF_T) return pack(4, WEND, GY, 1, 0, 1, 0, 0);
    if (k < WT + SNIFF_T + ALERT_T) return pack(5, WEND, GY, 1, 0, 1, 0, 0);
    j = k - (WT + SNIFF_T + ALERT_T);
    if (j < JU) return pack(6, WEND + j, GY - JP * j, 1, 0, 1, 0, 0);
    if (j < JU + JD) return pack(7, WEND + JU, PK + JP * (j - JU), 1, 0, 1, 0, 0);
    return pack(7, WEND + JU, HY, 0, 0, 0, fresh, 0);
  endfunction
  function automatic logic [30:0] round_exp(int k, bit fresh, bit hit, int bx, logic [3:0] s0);
    int s, x, y;
    s = hit ? int'(s0) : 8;
    x = hit ? bx : WEND;
    if (k >= ROUND_T) return pack(s, x, HY, 0, 0, 0, 0, fresh);
    y = k < RT ? HY - RP * k : k < RT + HOLD_T ? SY : SY + RP * (k - RT - HOLD_T);
    return pack(s, x, y, 1, hit, 1, 0, 0);
  endfunction
  task automatic drive(bit t, bit si, bit h, bit m, logic [10:0] bx);
    bus.frame_tick = t;
    bus.start_intro = si;
    bus.duck_hit = h;
    bus.duck_miss = m;
    bus.bird_x = bx;
    @(posedge clk);
    #1;
    bus.frame_tick = 0;
    bus.start_intro = 0;
    bus.duck_hit = 0;
    bus.duck_miss = 0;
  endtask
  task automatic test_reset();
    logic [30:0] e;
    drive(1, 0, 0, 0, 0);
    e = pack(0, WSTART, GY, 0, 0, 0, 0, 0);
    total_cnt++;
    if (obs !== e) $display("FAIL reset_hold got=%h exp=%h", obs, e); else pass_cnt++;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, i[0], i[1], 11'd77);
      total_cnt++;
      if (obs !== e) $display("FAIL idle_ignore got=%h exp=%h", obs, e); else pass_cnt++;
    end
  endtask
  task automatic test_async_reset();
    logic [30:0] e;
    drive(0, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      drive(1, 0, 0, 0, 0);
      e = intro_exp(i, 1);
      total_cnt++;
      if (obs !== e) $display("FAIL walk_pre_reset got=%h exp=%h", obs, e); else pass_cnt++;
    end
    #2 rst = 1;
    #1;
    e = pack(0, WSTART, GY, 0, 0, 0, 0, 0);
    total_cnt++;
    if (obs !== e) $display("FAIL async_reset got=%h exp=%h", obs, e); else pass_cnt++;
    @(posedge clk);
    #1 rst = 0;
    drive(1, 0, 1, 0, 11'd5);
    total_cnt++;
    if (obs !== e) $display("FAIL after_reset got=%h exp=%h", obs, e); else pass_cnt++;
  endtask
  task automatic test_intro(bit noise);
    logic [30:0] e;
    int k = 0;
    bit t, n;
    drive($urandom_range(0, 1) == 1, 1, 0, 0, 0);
    e = intro_exp(0, 0);
    total_cnt++;
    if (obs !== e) $display("FAIL intro_start got=%h exp=%h", obs, e); else pass_cnt++;
    for (int c = 0; c < 4000 && k < INTRO_T; c++) begin
      t = $urandom_range(0, 2) == 0;
      n = noise && $urandom_range(0, 3) == 0;
      drive(t, n && $urandom_range(0, 1) == 1, n && $urandom_range(0, 1) == 1, n && $urandom_range(0, 1) == 1,
            11'($urandom_range(0, 639)));
      if (t) k++;
      e = intro_exp(k, t);
      total_cnt++;
      if (obs !== e) $display("FAIL intro k=%0d got=%h exp=%h", k, obs, e); else pass_cnt++;
    end
    total_cnt++;
    if (k != INTRO_T) $display("FAIL intro_timeout ticks=%0d need=%0d", k, INTRO_T); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0);
      e = intro_exp(INTRO_T, 0);
      total_cnt++;
      if (obs !== e) $display("FAIL intro_settled got=%h exp=%h", obs, e); else pass_cnt++;
    end
    last_sel = 4'd7;
  endtask
  task automatic test_round(bit hit, bit miss, int bx, bit noise);
    logic [30:0] e;
    int k = 0;
    bit t, n, eff_hit;
    eff_hit = hit;
    drive($urandom_range(0, 1) == 1, 0, hit, miss, 11'(bx));
    e = round_exp(0, 0, eff_hit, bx, last_sel);
    total_cnt++;
    if (obs !== e) $display("FAIL round_start got=%h exp=%h", obs, e); else pass_cnt++;
    for (int c = 0; c < 3000 && k < ROUND_T; c++) begin
      t = $urandom_range(0, 2) == 0;
      n = noise && $urandom_range(0, 2) == 0;
      drive(t, n && $urandom_range(0, 1) == 1, n && $urandom_range(0, 1) == 1, n && $urandom_range(0, 1) == 1,
            11'($urandom_range(0, 639)));
      if (t) k++;
      e = round_exp(k, t, eff_hit, bx, last_sel);
      total_cnt++;
      if (obs !== e) $display("FAIL round k=%0d got=%h exp=%h", k, obs, e); else pass_cnt++;
    end
    total_cnt++;
    if (k != ROUND_T) $display("FAIL round_timeout ticks=%0d need=%0d", k, ROUND_T); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0);
      e = round_exp(ROUND_T, 0, eff_hit, bx, last_sel);
      total_cnt++;
      if (obs !== e) $display("FAIL round_settled got=%h exp=%h", obs, e); else pass_cnt++;
    end
    last_sel = eff_hit ? last_sel : 4'd8;
  endtask
  initial begin
    bus.frame_tick = 0;
    bus.start_intro = 0;
    bus.duck_hit = 0;
    bus.duck_miss = 0;
    bus.bird_x = 0;
    test_reset();
    test_async_reset();
    test_intro(0);
    test_round(1, 0, 333, 0);
    test_round(1, 1, int'($urandom_range(0, 600)), 1);
    test_round(0, 1, int'($urandom_range(0, 600)), 1);
    test_round(1, 0, int'($urandom_range(0, 600)), 1);
    test_intro(1);
    test_round(0, 1, 0, 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dog_anim_ctrl.md
Name: dog_anim_ctrl

Overview:
Sequencer for the dog sprite.
- Drives the frame index into the dog ROM and the dog position and visibility into the dog draw block.
- Selects between the dog sprite and the dog-with-bird sprite.
- Plays the intro walk/sniff/jump sequence, then the round-end reaction: rise with bird on a hit, rise laughing on a miss.
- Sits between the game FSM and the dog draw/ROM path. All motion advances on a per-frame tick.

Parameters:
WALK_START_X, 0, intro start x (px)
WALK_END_X, 200, x where walking stops
STEP_PX, 2, walk x increment per frame tick
FRAMES_PER_STEP, 6, frame ticks per walk-frame change
GROUND_Y, 560, walking y
JUMP_PEAK_Y, 460, jump apex y
HIDE_Y, 620, y fully behind grass
SHOW_Y, 540, y at top of reaction rise
JUMP_PX, 4, jump y step per tick
RISE_PX, 2, rise/fall y step per tick
SNIFF_TICKS, 40, sniff duration (ticks)
ALERT_TICKS, 20, alert duration
HOLD_TICKS, 60, reaction hold duration

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start_intro  in  1  pulse: begin intro sequence
duck_hit  in  1  pulse: round ended with duck shot
duck_miss  in  1  pulse: round ended with duck escaped
bird_x  in  11  x of shot duck, sampled on duck_hit
dog_select  out  4  dog ROM frame index 0..8
dog_xpos  out  11  sprite left x
dog_ypos  out  11  sprite top y
dog_visible  out  1  draw enable
show_bird  out  1  1 = use dog_bird image instead of dog_select frame
busy  out  1  sequence in progress
intro_done  out  1  one-cycle pulse, dog has hidden after intro
round_done  out  1  one-cycle pulse, reaction finished

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE, dog_select 0, dog_xpos WALK_START_X, dog_ypos GROUND_Y. dog_visible, show_bird, busy, intro_done and round_done are all 0.
- Frame map: 0-3 walk cycle, 4 sniff, 5 alert, 6 jump up, 7 jump down, 8 laugh.
- Timing rule: position, frame and timer changes happen only in a cycle with frame_tick=1. State transitions driven by start/hit/miss take effect the next clk edge, with no tick needed.
- IDLE: visible 0, busy 0. On start_intro: x=WALK_START_X, y=GROUND_Y, select 0, visible 1, go to WALK.
- WALK: per tick x+=STEP_PX, clamped to WALK_END_X. Every FRAMES_PER_STEP ticks select advances 0→1→2→3→0. When x==WALK_END_X: select 4, load SNIFF_TICKS, go to SNIFF.
- SNIFF: timer decrements per tick. At 0: select 5, load ALERT_TICKS, go to ALERT.
- ALERT: at timer 0: select 6, go to JUMP_UP.
- JUMP_UP: per tick y-=JUMP_PX and x+=1. y is clamped to JUMP_PEAK_Y. On reaching the peak: select 7, go to JUMP_DOWN.
- JUMP_DOWN: per tick y+=JUMP_PX, clamped to HIDE_Y. On reaching HIDE_Y: visible 0, intro_done pulse, go to HIDDEN.
- HIDDEN: busy 0.
  - On duck_hit: x=bird_x, show_bird 1.
  - On duck_miss: x=WALK_END_X, select 8, show_bird 0.
  - In both cases: y=HIDE_Y, visible 1, go to RISE.
  - Simultaneous hit and miss: hit wins.
  - start_intro in HIDDEN restarts the intro, as from IDLE.
- RISE: per tick y-=RISE_PX, clamped to SHOW_Y. At SHOW_Y: load HOLD_TICKS, go to HOLD.
- HOLD: at timer 0, go to FALL.
- FALL: per tick y+=RISE_PX, clamped to HIDE_Y. At HIDE_Y: visible 0, show_bird 0, round_done pulse, go to HIDDEN.
- Ignored inputs:
  - start_intro is ignored outside IDLE and HIDDEN.
  - duck_hit and duck_miss are ignored outside HIDDEN; they are not queued.
- Completion pulses: intro_done and round_done are high for exactly one clk cycle.
- busy: 1 in every state except IDLE and HIDDEN.
- Timer width: wide enough for the maximum *_TICKS value. Loading N gives a duration of N ticks; N=0 exits on the next tick.
- Reset mid-sequence: everything returns to the reset values immediately. No pulse is emitted.

Decomposition:
- Package dog_ctrl_pkg holds:
  - the state enum: IDLE, WALK, SNIFF, ALERT, JUMP_UP, JUMP_DOWN, HIDDEN, RISE, HOLD, FALL;
  - frame index constants: DOG_WALK0..3, DOG_SNIFF, DOG_ALERT, DOG_JUMP_UP, DOG_JUMP_DOWN, DOG_LAUGH;
  - coordinate widths.
- Sub-module dog_tick_timer: a load/decrement-on-frame_tick down counter with an expired flag.

Test Plan:
1. Reset asserted mid-WALK, asynchronously (no clk edge) → outputs immediately at reset values: select 0, x 0, y 560, visible 0.
2. start_intro, then 100 ticks → x 0→200 in steps of 2; select changes at ticks 6, 12, …; SNIFF entered with select 4, held 40 ticks; ALERT held 20 ticks.
3. Continue the intro → y 560→460 in 25 ticks (x +25), then 460→620 in 40 ticks; intro_done pulses for 1 cycle; visible 0; busy 0.
4. In HIDDEN, duck_hit with bird_x=333 → x 333, show_bird 1; y 620→540 in 40 ticks, hold 60 ticks, fall 40 ticks; round_done pulses once; show_bird returns to 0.
5. duck_hit and duck_miss in the same cycle → bird path taken. A second duck_miss during RISE is ignored: no second sequence afterwards.
6. duck_miss → select 8, x 200, same rise/hold/fall timing. start_intro during HOLD is ignored; start_intro in HIDDEN restarts WALK at x 0.
